// File: rtl/hazard_unit.sv
// Hazard detection and forwarding control for the 5-stage MIPS pipeline.
// Tracks M/W destination state internally and counts stalled decode cycles.
module hazard_unit #(
    parameter int unsigned REG_BITS  = 5,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [REG_BITS-1:0]  Rs_D,
    input  logic [REG_BITS-1:0]  Rt_D,
    input  logic                 Branch_D,
    input  logic [REG_BITS-1:0]  Rs_E,
    input  logic [REG_BITS-1:0]  Rt_E,
    input  logic [REG_BITS-1:0]  WriteReg_E,
    input  logic                 RegWrite_E,
    input  logic                 MemtoReg_E,
    output logic                 Stall_F,
    output logic                 Stall_D,
    output logic                 Flush_E,
    output logic [1:0]           ForwardA_E,
    output logic [1:0]           ForwardB_E,
    output logic                 ForwardA_D,
    output logic                 ForwardB_D,
    output logic [CNT_WIDTH-1:0] StallCount
);

    localparam logic [REG_BITS-1:0]  ZERO_REG = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    logic                reg_write_m;
    logic                mem_to_reg_m;
    logic [REG_BITS-1:0] write_reg_m;
    logic                reg_write_w;
    logic [REG_BITS-1:0] write_reg_w;

    logic lw_stall;
    logic br_stall;
    logic stall;

    // M/W scoreboard; E is already a bubble after a flush, so capture is unconditional
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reg_write_m  <= 1'b0;
            mem_to_reg_m <= 1'b0;
            write_reg_m  <= '0;
            reg_write_w  <= 1'b0;
            write_reg_w  <= '0;
        end else begin
            reg_write_m  <= RegWrite_E;
            mem_to_reg_m <= MemtoReg_E;
            write_reg_m  <= WriteReg_E;
            reg_write_w  <= reg_write_m;
            write_reg_w  <= write_reg_m;
        end
    end

    // EX forward selects, M stage wins over W stage
    always_comb begin
        ForwardA_E = FWD_RF;
        ForwardB_E = FWD_RF;
        if (Rs_E != ZERO_REG && reg_write_m && write_reg_m == Rs_E)
            ForwardA_E = FWD_MEM;
        else if (Rs_E != ZERO_REG && reg_write_w && write_reg_w == Rs_E)
            ForwardA_E = FWD_WB;
        if (Rt_E != ZERO_REG && reg_write_m && write_reg_m == Rt_E)
            ForwardB_E = FWD_MEM;
        else if (Rt_E != ZERO_REG && reg_write_w && write_reg_w == Rt_E)
            ForwardB_E = FWD_WB;
    end

    assign ForwardA_D = (Rs_D != ZERO_REG) && reg_write_m && (write_reg_m == Rs_D);
    assign ForwardB_D = (Rt_D != ZERO_REG) && reg_write_m && (write_reg_m == Rt_D);

    // Load-use and branch-compare hazards; both collapse into one stall
    always_comb begin
        lw_stall = MemtoReg_E && (WriteReg_E != ZERO_REG) &&
                   ((WriteReg_E == Rs_D) || (WriteReg_E == Rt_D));
        br_stall = Branch_D && (
                   (RegWrite_E && (WriteReg_E != ZERO_REG) &&
                    ((WriteReg_E == Rs_D) || (WriteReg_E == Rt_D))) ||
                   (mem_to_reg_m && (write_reg_m != ZERO_REG) &&
                    ((write_reg_m == Rs_D) || (write_reg_m == Rt_D))));
        stall    = lw_stall | br_stall;
    end

    assign Stall_F = stall;
    assign Stall_D = stall;
    assign Flush_E = stall;

    // Saturating count of stalled decode cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            StallCount <= '0;
        else if (stall && StallCount != CNT_MAX)
            StallCount <= StallCount + CNT_WIDTH'(1);
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit; a second instance with a
// 4-bit counter shares the same stimulus to exercise saturation.
module tb_hazard_unit;

    logic       clk;
    logic       reset_n;
    logic [4:0] rs_d, rt_d, rs_e, rt_e, write_reg_e;
    logic       branch_d, reg_write_e, mem_to_reg_e;

    logic        stall_f, stall_d, flush_e, fwd_a_d, fwd_b_d;
    logic [1:0]  fwd_a_e, fwd_b_e;
    logic [15:0] stall_count;

    logic        stall_f4, stall_d4, flush_e4, fwd_a_d4, fwd_b_d4;
    logic [1:0]  fwd_a_e4, fwd_b_e4;
    logic [3:0]  stall_count4;

    int total = 0;
    int bad   = 0;

    hazard_unit dut (
        .clk(clk), .reset_n(reset_n),
        .Rs_D(rs_d), .Rt_D(rt_d), .Branch_D(branch_d),
        .Rs_E(rs_e), .Rt_E(rt_e), .WriteReg_E(write_reg_e),
        .RegWrite_E(reg_write_e), .MemtoReg_E(mem_to_reg_e),
        .Stall_F(stall_f), .Stall_D(stall_d), .Flush_E(flush_e),
        .ForwardA_E(fwd_a_e), .ForwardB_E(fwd_b_e),
        .ForwardA_D(fwd_a_d), .ForwardB_D(fwd_b_d),
        .StallCount(stall_count)
    );

    hazard_unit #(.REG_BITS(5), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .reset_n(reset_n),
        .Rs_D(rs_d), .Rt_D(rt_d), .Branch_D(branch_d),
        .Rs_E(rs_e), .Rt_E(rt_e), .WriteReg_E(write_reg_e),
        .RegWrite_E(reg_write_e), .MemtoReg_E(mem_to_reg_e),
        .Stall_F(stall_f4), .Stall_D(stall_d4), .Flush_E(flush_e4),
        .ForwardA_E(fwd_a_e4), .ForwardB_E(fwd_b_e4),
        .ForwardA_D(fwd_a_d4), .ForwardB_D(fwd_b_d4),
        .StallCount(stall_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_stall(input string tag, input logic exp);
        chk({tag, "_stall_f"}, 32'(stall_f), 32'(exp));
        chk({tag, "_stall_d"}, 32'(stall_d), 32'(exp));
        chk({tag, "_flush_e"}, 32'(flush_e), 32'(exp));
    endtask

    task automatic clear_inputs();
        rs_d = '0; rt_d = '0; branch_d = 1'b0;
        rs_e = '0; rt_e = '0; write_reg_e = '0;
        reg_write_e = 1'b0; mem_to_reg_e = 1'b0;
    endtask

    // Inputs change 1ns after the rising edge; checks happen on the falling edge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_fa_e", 32'(fwd_a_e), 32'd0);
        chk("rst_fb_e", 32'(fwd_b_e), 32'd0);
        chk("rst_fa_d", 32'(fwd_a_d), 32'd0);
        chk("rst_fb_d", 32'(fwd_b_d), 32'd0);
        chk_stall("rst", 1'b0);
        chk("rst_cnt", 32'(stall_count), 32'd0);

        // add $3 in E, then consumers in the next two cycles
        next_cycle(); reg_write_e = 1'b1; write_reg_e = 5'd3;
        @(negedge clk); chk("add3_e_fa", 32'(fwd_a_e), 32'd0);
        next_cycle(); clear_inputs(); rs_e = 5'd3;
        @(negedge clk); chk("fwd_m_a", 32'(fwd_a_e), 32'd2);
        next_cycle(); clear_inputs(); rt_e = 5'd3;
        @(negedge clk);
        chk("fwd_w_b", 32'(fwd_b_e), 32'd1);
        chk("fwd_w_a0", 32'(fwd_a_e), 32'd0);

        // Same sequence targeting $0: never forwarded
        next_cycle(); clear_inputs(); reg_write_e = 1'b1;
        next_cycle(); clear_inputs();
        @(negedge clk);
        chk("r0_m_a", 32'(fwd_a_e), 32'd0);
        chk("r0_m_b", 32'(fwd_b_e), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("r0_w_a", 32'(fwd_a_e), 32'd0);
        chk("r0_w_b", 32'(fwd_b_e), 32'd0);

        // $5 written twice back to back: M beats W
        next_cycle(); clear_inputs(); reg_write_e = 1'b1; write_reg_e = 5'd5;
        next_cycle();
        next_cycle(); clear_inputs(); rs_e = 5'd5; rt_e = 5'd5; rs_d = 5'd5;
        @(negedge clk);
        chk("prio_a", 32'(fwd_a_e), 32'd2);
        chk("prio_b", 32'(fwd_b_e), 32'd2);
        chk("prio_fa_d", 32'(fwd_a_d), 32'd1);
        chk_stall("prio", 1'b0);
        next_cycle();
        @(negedge clk);
        chk("prio_w_a", 32'(fwd_a_e), 32'd1);
        chk("prio_w_fa_d", 32'(fwd_a_d), 32'd0);

        // Load-use: lw $7 in E, consumer of $7 in D
        next_cycle(); clear_inputs();
        next_cycle(); clear_inputs();
        mem_to_reg_e = 1'b1; reg_write_e = 1'b1; write_reg_e = 5'd7; rt_d = 5'd7;
        @(negedge clk);
        chk_stall("lw", 1'b1);
        chk("lw_cnt0", 32'(stall_count), 32'd0);
        next_cycle(); clear_inputs(); rt_d = 5'd7;
        @(negedge clk);
        chk_stall("lw_bubble", 1'b0);
        chk("lw_cnt1", 32'(stall_count), 32'd1);
        next_cycle(); clear_inputs(); rt_e = 5'd7;
        @(negedge clk);
        chk("lw_fwd_b", 32'(fwd_b_e), 32'd1);

        // Branch on $4 right behind lw $4: two stall cycles
        next_cycle(); clear_inputs();
        mem_to_reg_e = 1'b1; reg_write_e = 1'b1; write_reg_e = 5'd4;
        branch_d = 1'b1; rs_d = 5'd4;
        @(negedge clk); chk_stall("brlw1", 1'b1);
        next_cycle(); clear_inputs(); branch_d = 1'b1; rs_d = 5'd4;
        @(negedge clk); chk_stall("brlw2", 1'b1);
        next_cycle();
        @(negedge clk);
        chk_stall("brlw3", 1'b0);
        chk("brlw3_fa_d", 32'(fwd_a_d), 32'd0);
        chk("brlw_cnt", 32'(stall_count), 32'd3);

        // Branch on $9 right behind add $9: one stall, then compare-forward
        next_cycle(); clear_inputs();
        reg_write_e = 1'b1; write_reg_e = 5'd9; branch_d = 1'b1; rt_d = 5'd9;
        @(negedge clk); chk_stall("bralu1", 1'b1);
        next_cycle(); clear_inputs(); branch_d = 1'b1; rt_d = 5'd9;
        @(negedge clk);
        chk_stall("bralu2", 1'b0);
        chk("bralu_fb_d", 32'(fwd_b_d), 32'd1);
        chk("bralu_cnt", 32'(stall_count), 32'd4);

        // Load into $0 never stalls, in E or in M
        next_cycle(); clear_inputs();
        mem_to_reg_e = 1'b1; reg_write_e = 1'b1; branch_d = 1'b1;
        @(negedge clk); chk_stall("lw0_e", 1'b0);
        next_cycle(); clear_inputs(); branch_d = 1'b1;
        @(negedge clk);
        chk_stall("lw0_m", 1'b0);
        chk("lw0_fa_d", 32'(fwd_a_d), 32'd0);
        chk("lw0_cnt4", 32'(stall_count4), 32'd4);

        // Async reset with $6 in M: clears without a clock edge
        next_cycle(); clear_inputs(); reg_write_e = 1'b1; write_reg_e = 5'd6;
        next_cycle(); clear_inputs(); rs_e = 5'd6; rs_d = 5'd6;
        @(negedge clk);
        chk("ar_pre_fa_e", 32'(fwd_a_e), 32'd2);
        chk("ar_pre_fa_d", 32'(fwd_a_d), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("ar_fa_e", 32'(fwd_a_e), 32'd0);
        chk("ar_fa_d", 32'(fwd_a_d), 32'd0);
        chk("ar_cnt", 32'(stall_count), 32'd0);
        chk("ar_cnt4", 32'(stall_count4), 32'd0);
        // Live E-stage load hazard still stalls while in reset
        mem_to_reg_e = 1'b1; write_reg_e = 5'd8; rt_d = 5'd8;
        #1 chk_stall("ar_lw", 1'b1);
        @(posedge clk); #1;
        chk("ar_cnt_hold", 32'(stall_count), 32'd0);
        clear_inputs();
        reset_n = 1'b1;

        // 20 load-use stall cycles: 16-bit counter reaches 20, 4-bit sticks at 15
        next_cycle(); clear_inputs();
        mem_to_reg_e = 1'b1; reg_write_e = 1'b1; write_reg_e = 5'd2; rs_d = 5'd2;
        repeat (16) @(posedge clk);
        #1 chk("sat_cnt4_16", 32'(stall_count4), 32'd15);
        repeat (4) @(posedge clk);
        #1 clear_inputs();
        @(negedge clk);
        chk("sat_cnt4", 32'(stall_count4), 32'd15);
        chk("sat_cnt16", 32'(stall_count), 32'd20);
        next_cycle();
        chk("sat_idle", 32'(stall_count), 32'd20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Hazard-detection and forwarding-control block for the 5-stage MIPS pipeline.
- Generates the 2-bit EX-stage forward selects and the 1-bit decode-stage branch-compare forward selects. Raises stall and flush for load-use and branch hazards.
- Keeps its own M- and W-stage scoreboard, registered from E-stage control each cycle, plus a saturating stall-cycle counter for performance debug.
- Sits beside the datapath; its outputs drive the F/D pipeline-register enables, the E-register clear, and the EX forward muxes.

Parameters:
- REG_BITS, 5, width of register specifiers.
- CNT_WIDTH, 16, width of the stall-cycle counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- Rs_D  input  REG_BITS  decode-stage source register 1.
- Rt_D  input  REG_BITS  decode-stage source register 2.
- Branch_D  input  1  decode-stage instruction is a branch compared in D.
- Rs_E  input  REG_BITS  execute-stage source register 1.
- Rt_E  input  REG_BITS  execute-stage source register 2.
- WriteReg_E  input  REG_BITS  execute-stage destination (post RegDst mux).
- RegWrite_E  input  1  execute-stage instruction writes the register file.
- MemtoReg_E  input  1  execute-stage instruction is a load.
- Stall_F  output  1  hold the PC.
- Stall_D  output  1  hold the F/D register.
- Flush_E  output  1  clear the D/E register (insert bubble).
- ForwardA_E  output  2  SrcA select: 00 register file, 01 Result_W, 10 ALUOut_M; 11 never driven.
- ForwardB_E  output  2  WriteData select, same encoding as ForwardA_E.
- ForwardA_D  output  1  branch-compare operand A comes from ALUOut_M.
- ForwardB_D  output  1  branch-compare operand B comes from ALUOut_M.
- StallCount  output  CNT_WIDTH  number of cycles with Stall_D asserted since reset.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Internal scoreboard registers: RegWrite_M, MemtoReg_M, WriteReg_M, RegWrite_W, WriteReg_W.
- Scoreboard update, every rising edge:
  - RegWrite_M <= RegWrite_E; MemtoReg_M <= MemtoReg_E; WriteReg_M <= WriteReg_E.
  - RegWrite_W <= RegWrite_M; WriteReg_W <= WriteReg_M.
  - E/M and M/W never stall. Flush_E does not gate capture: the external D/E clear already turns E into a bubble on the next cycle.
- Reset (reset_n low, asynchronous): all scoreboard registers go to 0 and StallCount goes to 0. Consequently, with RegWrite_E=0 after reset, all Forward* outputs = 0. Reset mid-stall drops the stall immediately, unless the E inputs still match.
- Forward outputs are combinational from the scoreboard and current inputs, valid in the same cycle.
- ForwardA_E:
  - 10 if Rs_E != 0 && RegWrite_M && WriteReg_M == Rs_E;
  - else 01 if Rs_E != 0 && RegWrite_W && WriteReg_W == Rs_E;
  - else 00.
  - M has priority over W when both match.
- ForwardB_E: identical to ForwardA_E, using Rt_E.
- Register $0 is never forwarded and never causes a stall.
- ForwardA_D = Rs_D != 0 && RegWrite_M && WriteReg_M == Rs_D. ForwardB_D is the same with Rt_D.
- lwstall = MemtoReg_E && WriteReg_E != 0 && (WriteReg_E == Rs_D || WriteReg_E == Rt_D).
- brstall = Branch_D && (
  - (RegWrite_E && WriteReg_E != 0 && WriteReg_E ∈ {Rs_D, Rt_D})
  - || (MemtoReg_M && WriteReg_M != 0 && WriteReg_M ∈ {Rs_D, Rt_D}) ).
- Stall_F = Stall_D = Flush_E = lwstall | brstall.
- Latency:
  - A load followed by a dependent instruction causes exactly one stall cycle.
  - A branch depending on a load immediately ahead causes two stall cycles: first via the E term, then via the MemtoReg_M term.
- StallCount increments on each rising edge where Stall_D = 1, and saturates at all-ones (no wrap).
- Simultaneous lwstall and brstall: a single stall. The counter increments by 1.

Test Plan:
- Reset: hold reset_n=0, then release with all inputs 0 -> all outputs 0 and StallCount=0. Assert reset_n=0 asynchronously mid-clock with scoreboard loaded -> Forward* and StallCount clear without a clock edge.
- EX forwarding:
  - add $3 writes (RegWrite_E=1, WriteReg_E=3) for one cycle; next cycle Rs_E=3 -> ForwardA_E=10.
  - Following cycle, Rt_E=3 with no new writer -> ForwardB_E=01.
  - Same sequence with WriteReg_E=0 -> both 00.
- Priority: $5 written two consecutive cycles, then Rs_E=Rt_E=5 -> ForwardA_E=ForwardB_E=10 (M wins over W).
- Load-use: MemtoReg_E=1, WriteReg_E=7, Rt_D=7 -> Stall_F=Stall_D=Flush_E=1 for that cycle only. StallCount increments 0->1. Next cycle, Rt_E=7 -> ForwardB_E=01.
- Branch after load: lw $4 in E, Branch_D=1 with Rs_D=4, held for two cycles -> stall in both cycles, released in cycle 3 with ForwardA_D=0. StallCount=2.
- Branch after ALU op: add $9 in E and Branch_D=1 with Rt_D=9 -> one stall cycle. Next cycle, ForwardB_D=1 and no stall.
- Counter saturation: with CNT_WIDTH=4, force 20 stall cycles -> StallCount stays at 15.
